nios_multi_timer: RTL and testbench

- Parametrised successor to the single-channel Avalon interval timer. Provides NUM_CHANNELS independent down-counting interval timers of COUNTER_WIDTH bits.
- Each channel has its own programmable prescaler, one-shot or continuous mode, snapshot register and interrupt.
- Sits on the Nios II Avalon-MM data bus as a single 32-bit slave. Drives a combined irq and a per-channel irq vector, e.g. the accelerometer sample tick plus spare tick sources.

---
 rtl/nios_multi_timer_pkg.sv | 22 ++
 rtl/nios_multi_timer_channel.sv | 150 +++++++++++++++
 rtl/nios_multi_timer.sv | 84 ++++++++
 tb/tb_nios_multi_timer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/nios_multi_timer_pkg.sv
// Shared definitions for the multi-channel Avalon interval timer.
//   - per-channel register offsets (low 3 address bits)
//   - CONTROL and STATUS bit positions
package nios_multi_timer_pkg;

    typedef enum logic [2:0] {
        REG_STATUS   = 3'd0,
        REG_CONTROL  = 3'd1,
        REG_PERIOD   = 3'd2,
        REG_SNAPSHOT = 3'd3,
        REG_PRESCALE = 3'd4
    } reg_off_e;

    localparam int unsigned CTL_ITO   = 0;
    localparam int unsigned CTL_CONT  = 1;
    localparam int unsigned CTL_START = 2;
    localparam int unsigned CTL_STOP  = 3;

    localparam int unsigned ST_TO  = 0;
    localparam int unsigned ST_RUN = 1;

endpackage

// File: rtl/nios_multi_timer_channel.sv
// One timer channel: period/prescale/control/snapshot registers, prescaler,
// down counter, RUN and TO flags, and the channel interrupt.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   i_wr         write strobe already qualified for this channel
//   i_reg_sel    register offset within the channel
//   i_wdata      bus write data
//   o_rdata      combinational read data for the selected offset
//   o_irq        TO & ITO
module nios_multi_timer_channel
    import nios_multi_timer_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH  = 32,
    parameter int unsigned PRESCALE_WIDTH = 16,
    parameter int unsigned DEFAULT_PERIOD = 49999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wr,
    input  logic [2:0]  i_reg_sel,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    logic [COUNTER_WIDTH-1:0]  r_period;
    logic [COUNTER_WIDTH-1:0]  r_counter;
    logic [COUNTER_WIDTH-1:0]  r_snapshot;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] r_prescale_cnt;
    logic                      r_cont;
    logic                      r_ito;
    logic                      r_run;
    logic                      r_to;
    logic                      r_force_reload;
    logic                      r_zero_d;

    logic w_wr_status;
    logic w_wr_control;
    logic w_wr_period;
    logic w_wr_snapshot;
    logic w_wr_prescale;
    logic w_start;
    logic w_stop;
    logic w_tick;
    logic w_zero;
    logic w_timeout;
    logic w_expire;
    logic w_unused_wdata;

    assign w_wr_status   = i_wr & (reg_off_e'(i_reg_sel) == REG_STATUS);
    assign w_wr_control  = i_wr & (reg_off_e'(i_reg_sel) == REG_CONTROL);
    assign w_wr_period   = i_wr & (reg_off_e'(i_reg_sel) == REG_PERIOD);
    assign w_wr_snapshot = i_wr & (reg_off_e'(i_reg_sel) == REG_SNAPSHOT);
    assign w_wr_prescale = i_wr & (reg_off_e'(i_reg_sel) == REG_PRESCALE);

    assign w_start = w_wr_control & i_wdata[CTL_START];
    assign w_stop  = w_wr_control & i_wdata[CTL_STOP];

    assign w_tick    = r_run & (r_prescale_cnt == r_prescale);
    assign w_zero    = (r_counter == '0);
    // Rising edge of counter==0; a counter parked at zero yields one event.
    assign w_timeout = w_zero & ~r_zero_d;
    assign w_expire  = w_zero & w_tick & ~r_cont;

    assign w_unused_wdata = ^i_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_period       <= COUNTER_WIDTH'(DEFAULT_PERIOD);
            r_counter      <= COUNTER_WIDTH'(DEFAULT_PERIOD);
            r_snapshot     <= '0;
            r_prescale     <= '0;
            r_prescale_cnt <= '0;
            r_cont         <= 1'b0;
            r_ito          <= 1'b0;
            r_run          <= 1'b0;
            r_to           <= 1'b0;
            r_force_reload <= 1'b0;
            // Match the reset counter so no edge is seen straight out of reset.
            r_zero_d       <= (DEFAULT_PERIOD == 0);
        end else begin
            r_force_reload <= w_wr_period;
            r_zero_d       <= w_zero;

            if (w_wr_period) begin
                r_period <= i_wdata[COUNTER_WIDTH-1:0];
            end
            if (w_wr_prescale) begin
                r_prescale <= i_wdata[PRESCALE_WIDTH-1:0];
            end
            if (w_wr_control) begin
                r_cont <= i_wdata[CTL_CONT];
                r_ito  <= i_wdata[CTL_ITO];
            end
            if (w_wr_snapshot) begin
                r_snapshot <= r_counter;
            end

            if (r_force_reload || w_wr_prescale) begin
                r_prescale_cnt <= '0;
            end else if (w_tick) begin
                r_prescale_cnt <= '0;
            end else if (r_run) begin
                r_prescale_cnt <= r_prescale_cnt + PRESCALE_WIDTH'(1);
            end

            if (r_force_reload) begin
                r_counter <= r_period;
            end else if (w_tick && w_zero) begin
                r_counter <= r_period;
            end else if (w_tick) begin
                r_counter <= r_counter - COUNTER_WIDTH'(1);
            end

            if (w_start) begin
                r_run <= 1'b1;
            end else if (w_stop || r_force_reload || w_expire) begin
                r_run <= 1'b0;
            end

            if (w_wr_status) begin
                r_to <= 1'b0;
            end else if (w_timeout) begin
                r_to <= 1'b1;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        case (reg_off_e'(i_reg_sel))
            REG_STATUS: begin
                o_rdata[ST_TO]  = r_to;
                o_rdata[ST_RUN] = r_run;
            end
            REG_CONTROL: begin
                o_rdata[CTL_ITO]  = r_ito;
                o_rdata[CTL_CONT] = r_cont;
            end
            REG_PERIOD:   o_rdata = 32'(r_period);
            REG_SNAPSHOT: o_rdata = 32'(r_snapshot);
            REG_PRESCALE: o_rdata = 32'(r_prescale);
            default:      o_rdata = '0;
        endcase
    end

    assign o_irq = r_to & r_ito;

endmodule

// File: rtl/nios_multi_timer.sv
// Multi-channel Avalon-MM interval timer.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   address             {channel index, 3-bit register offset}
//   chipselect, write_n write strobe = chipselect & ~write_n
//   read_n              unused; reads have no side effects
//   writedata           write data
//   readdata            registered read data (1-cycle latency)
//   irq, irq_vector     combined and per-channel interrupts
module nios_multi_timer
    import nios_multi_timer_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned COUNTER_WIDTH  = 32,
    parameter int unsigned PRESCALE_WIDTH = 16,
    parameter int unsigned DEFAULT_PERIOD = 49999
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [2+$clog2(NUM_CHANNELS):0]      address,
    input  logic                                 chipselect,
    input  logic                                 write_n,
    input  logic                                 read_n,
    input  logic [31:0]                          writedata,
    output logic [31:0]                          readdata,
    output logic                                 irq,
    output logic [NUM_CHANNELS-1:0]              irq_vector
);

    localparam int unsigned ADDR_W = 3 + $clog2(NUM_CHANNELS);

    logic                    w_wr;
    logic [ADDR_W-1:0]       w_ch_sel;
    logic [NUM_CHANNELS-1:0] w_ch_wr;
    logic [31:0]             w_ch_rdata [NUM_CHANNELS];
    logic [31:0]             w_rdata;
    logic [31:0]             r_readdata;
    logic                    w_unused;

    assign w_wr     = chipselect & ~write_n;
    // Shift rather than slice so a single-channel build has no empty range.
    assign w_ch_sel = address >> 3;
    assign w_unused = read_n;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign w_ch_wr[i] = w_wr & (w_ch_sel == ADDR_W'(i));

        nios_multi_timer_channel #(
            .COUNTER_WIDTH  (COUNTER_WIDTH),
            .PRESCALE_WIDTH (PRESCALE_WIDTH),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_wr      (w_ch_wr[i]),
            .i_reg_sel (address[2:0]),
            .i_wdata   (writedata),
            .o_rdata   (w_ch_rdata[i]),
            .o_irq     (irq_vector[i])
        );
    end

    // Channel indices beyond NUM_CHANNELS fall through to zero.
    always_comb begin
        w_rdata = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (w_ch_sel == ADDR_W'(i)) begin
                w_rdata = w_ch_rdata[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdata;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |irq_vector;

endmodule

// File: tb/tb_nios_multi_timer.sv
// Directed bench for nios_multi_timer (4 channels, 32-bit counters).
// Inputs change on negedge; register reads return the state seen at the
// following posedge, irq lines are sampled at negedge.
module tb_nios_multi_timer;

    logic        clk;
    logic        reset;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  irq_vector;

    int unsigned n_checks;
    int unsigned n_pass;
    logic [31:0] v;

    nios_multi_timer #(
        .NUM_CHANNELS   (4),
        .COUNTER_WIDTH  (32),
        .PRESCALE_WIDTH (16),
        .DEFAULT_PERIOD (49999)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_vector (irq_vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] a(input int unsigned ch, input int unsigned off);
        return 5'(ch * 8 + off);
    endfunction

    // Both tasks start and end at a negedge and consume one clock.
    task automatic wr(input logic [4:0] ad, input logic [31:0] d);
        address    = ad;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [4:0] ad, output logic [31:0] d);
        address    = ad;
        chipselect = 1'b1;
        read_n     = 1'b0;
        @(posedge clk);
        #1 d = readdata;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
        writedata  = '0;
        idle(2);
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_irqvec", {28'd0, irq_vector}, 32'd0);
        reset = 1'b0;
        rd(a(0, 2), v); check("rst_ch0_period", v, 32'd49999);
        rd(a(3, 0), v); check("rst_ch3_status", v, 32'd0);

        // Channel 1: period 4, continuous, TO every 5 cycles (start edge S)
        wr(a(1, 2), 32'd4);
        wr(a(1, 4), 32'd0);
        wr(a(1, 1), 32'h7);                                   // S
        idle(4); check("ch1_irq_pre", {31'd0, irq}, 32'd0);   // S+4
        idle(1); check("ch1_irq_set", {31'd0, irq}, 32'd1);   // S+5
        check("ch1_irqvec", {28'd0, irq_vector}, 32'h2);
        rd(a(1, 0), v); check("ch1_status", v, 32'd3);        // S+6
        wr(a(1, 0), 32'd0);                                   // S+7
        check("ch1_irq_clr", {31'd0, irq}, 32'd0);
        idle(2); check("ch1_irq_pre2", {31'd0, irq}, 32'd0);  // S+9
        idle(1); check("ch1_irq_set2", {31'd0, irq}, 32'd1);  // S+10
        wr(a(1, 0), 32'd0);                                   // S+11
        idle(3);                                              // S+14
        wr(a(1, 0), 32'd0);                                   // S+15, same edge as event
        check("ch1_clr_wins_irq", {31'd0, irq}, 32'd0);
        rd(a(1, 0), v); check("ch1_clr_wins_st", v, 32'd2);   // S+16
        wr(a(1, 1), 32'h8);                                   // S+17 stop
        rd(a(1, 0), v); check("ch1_stopped", v, 32'd0);

        // Channel 2: period 3, prescale 2, one-shot with ITO
        wr(a(2, 2), 32'd3);
        wr(a(2, 4), 32'd2);
        wr(a(2, 1), 32'h5);                                   // S
        idle(3);
        wr(a(2, 3), 32'd0);                                   // S+4 snapshot
        rd(a(2, 3), v); check("ch2_snap_step", v, 32'd2);     // S+5
        idle(4); check("ch2_irqvec_pre", {28'd0, irq_vector}, 32'h0);  // S+9
        wr(a(2, 3), 32'd0);                                   // S+10
        check("ch2_irqvec_set", {28'd0, irq_vector}, 32'h4);
        rd(a(2, 3), v); check("ch2_snap_zero", v, 32'd0);     // S+11
        rd(a(2, 0), v); check("ch2_st_running", v, 32'd3);    // S+12
        rd(a(2, 0), v); check("ch2_st_expired", v, 32'd1);    // S+13
        wr(a(2, 0), 32'd0);
        check("ch2_irq_clr", {31'd0, irq}, 32'd0);

        // Channel 0: snapshot while counting, period write mid-count
        wr(a(0, 2), 32'd30);
        wr(a(0, 4), 32'd0);
        wr(a(0, 1), 32'h6);                                   // S
        idle(13);
        wr(a(0, 3), 32'd0);                                   // S+14
        rd(a(0, 3), v); check("ch0_snap17", v, 32'd17);
        wr(a(0, 3), 32'd0);                                   // S+16
        rd(a(0, 3), v); check("ch0_snap15", v, 32'd15);
        wr(a(0, 2), 32'd100);                                 // S+18
        rd(a(0, 0), v); check("ch0_run_before_reload", v, 32'd2);
        rd(a(0, 0), v); check("ch0_run_after_reload", v, 32'd0);
        wr(a(0, 3), 32'd0);
        rd(a(0, 3), v); check("ch0_counter_reloaded", v, 32'd100);
        rd(a(0, 2), v); check("ch0_period", v, 32'd100);
        wr(a(0, 1), 32'hC);                                   // start+stop
        rd(a(0, 0), v); check("ch0_start_wins", v, 32'd2);
        rd(a(0, 1), v); check("ch0_ctl_strobes", v, 32'd0);
        wr(a(0, 1), 32'h8);
        rd(a(0, 0), v); check("ch0_stop", v, 32'd0);

        // Channel 3: width masking, unmapped offset, period 0 continuous
        wr(a(3, 4), 32'hABC12345);
        rd(a(3, 4), v); check("ch3_prescale_mask", v, 32'h2345);
        wr(a(3, 4), 32'd0);
        rd(a(3, 5), v); check("ch3_unmapped", v, 32'd0);
        wr(a(3, 2), 32'd0);
        wr(a(3, 1), 32'h7);                                   // S
        rd(a(3, 1), v); check("ch3_ctl", v, 32'd3);           // S+1
        check("ch3_irqvec", {28'd0, irq_vector}, 32'h8);
        wr(a(3, 0), 32'd0);                                   // S+2
        idle(4);
        check("ch3_single_event", {28'd0, irq_vector}, 32'h0);
        rd(a(3, 0), v); check("ch3_run_held", v, 32'd2);

        // Reset while counting
        wr(a(0, 1), 32'h7);
        rd(a(3, 0), v); check("pre_reset_st", v, 32'd2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("mid_rst_readdata", readdata, 32'd0);
        check("mid_rst_irqvec", {28'd0, irq_vector}, 32'h0);
        rd(a(0, 2), v); check("mid_rst_ch0_period", v, 32'd49999);
        rd(a(0, 3), v); check("mid_rst_ch0_snap", v, 32'd0);
        rd(a(3, 0), v); check("mid_rst_ch3_status", v, 32'd0);
        rd(a(3, 4), v); check("mid_rst_ch3_prescale", v, 32'd0);
        rd(a(2, 1), v); check("mid_rst_ch2_ctl", v, 32'd0);
        idle(10);
        check("post_rst_irq", {31'd0, irq}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
